rr_mux4_arbiter: RTL and testbench

Round-robin arbiter and registered 4:1 datapath that shares one W-bit output bus among four requesters. It grants one requester at a time, drives the 2-bit select CD for the 4:1 selection, and registers the selected word onto F with a valid/ready handshake toward the sink. It sits between four producer blocks and a single shared consumer, and replaces free-running select logic with a clocked, fair scheduler.

---
 rtl/rr_mux4_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter for four requesters feeding a registered 4:1 data path.
// One source owns the output bus at a time. The owner is rotated after HOLD_MAX
// transfers, or as soon as its request drops. The next owner is chosen on the
// same edge, so the bus never sits idle between grants.
module rr_mux4_arbiter #(
  parameter int W        = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic         rdy,
  output logic [3:0]   gnt,
  output logic [1:0]   CD,
  output logic [W-1:0] F,
  output logic         F_valid,
  output logic         busy
);

  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t         r_state, w_state_nx;
  logic [3:0]     r_gnt, w_gnt_nx;
  logic [1:0]     r_cd, w_cd_nx;
  logic [1:0]     r_ptr, w_ptr_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_f, w_f_nx;
  logic           r_fv, w_fv_nx;

  logic [W-1:0]   w_sel;
  logic [CW-1:0]  w_cnt_inc;
  logic [1:0]     w_ptr_rel;
  logic [2:0]     w_pick_idle;
  logic [2:0]     w_pick_rel;

  // First set request in the order p, p+1, p+2, p+3 (mod 4).
  // The result is {found, index}.
  function automatic logic [2:0] f_pick(input logic [1:0] p, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    // Scan from the farthest slot back to p, so the nearest hit wins.
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_ptr_rel   = r_cd + 2'd1;
  assign w_pick_idle = f_pick(r_ptr, req);
  assign w_pick_rel  = f_pick(w_ptr_rel, req);

  // 4:1 data select driven by the registered grant index
  always_comb begin
    w_sel = I0;
    case (r_cd)
      2'd0: w_sel = I0;
      2'd1: w_sel = I1;
      2'd2: w_sel = I2;
      2'd3: w_sel = I3;
      default: w_sel = I0;
    endcase
  end

  // Next-state, arbitration and transfer decision
  always_comb begin
    logic rel;
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_cd_nx    = r_cd;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_f_nx     = r_f;
    w_fv_nx    = 1'b0;
    rel        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nx = ST_OWN;
          w_cd_nx    = w_pick_idle[1:0];
          w_gnt_nx   = 4'b0001 << w_pick_idle[1:0];
          w_cnt_nx   = '0;
        end
      end
      ST_OWN: begin
        if (req[r_cd]) begin
          if (rdy) begin
            w_f_nx   = w_sel;
            w_fv_nx  = 1'b1;
            w_cnt_nx = w_cnt_inc;
            rel      = (w_cnt_inc == CW'(HOLD_MAX));
          end
        end else begin
          rel = 1'b1;
        end
        // Release: move priority past the current owner and re-arbitrate now.
        // The current owner can win again if it is the only requester.
        if (rel) begin
          w_ptr_nx = w_ptr_rel;
          w_cnt_nx = '0;
          if (w_pick_rel[2]) begin
            w_cd_nx  = w_pick_rel[1:0];
            w_gnt_nx = 4'b0001 << w_pick_rel[1:0];
          end else begin
            w_state_nx = ST_IDLE;
            w_gnt_nx   = 4'b0000;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_cd    <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_f     <= '0;
      r_fv    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_cd    <= w_cd_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_f     <= w_f_nx;
      r_fv    <= w_fv_nx;
    end
  end

  assign gnt     = r_gnt;
  assign CD      = r_cd;
  assign F       = r_f;
  assign F_valid = r_fv;
  assign busy    = (r_state == ST_OWN);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter.
// It runs directed scenarios and then random traffic. A cycle-level
// behavioural model of owner, priority and hold count predicts every output.
module tb_rr_mux4_arbiter;
  localparam int W  = 4;
  localparam int HM = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] dat [4];
  logic         rdy;
  logic [3:0]   gnt;
  logic [1:0]   CD;
  logic [W-1:0] F;
  logic         F_valid;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: owner is -1 when idle
  int m_own, m_ptr, m_cnt, m_cd, m_f, m_fv;

  rr_mux4_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .I0(dat[0]), .I1(dat[1]), .I2(dat[2]), .I3(dat[3]),
    .rdy(rdy), .gnt(gnt), .CD(CD), .F(F), .F_valid(F_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic m_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_cd = 0; m_f = 0; m_fv = 0;
  endtask

  // One clock edge of the model, using the inputs present before the edge
  task automatic m_step();
    int w;
    bit rel;
    rel = 0;
    if (m_own < 0) begin
      m_fv = 0;
      w = pick(m_ptr, req);
      if (w >= 0) begin m_own = w; m_cd = w; m_cnt = 0; end
    end else begin
      m_fv = 0;
      if (req[m_own] && rdy) begin
        m_f = int'(dat[m_own]); m_fv = 1; m_cnt++;
        if (m_cnt == HM) rel = 1;
      end else if (!req[m_own]) rel = 1;
      if (rel) begin
        m_ptr = (m_own + 1) % 4;
        m_cnt = 0;
        w = pick(m_ptr, req);
        if (w >= 0) begin m_own = w; m_cd = w; end
        else m_own = -1;
      end
    end
  endtask

  task automatic compare();
    chk("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
    chk("CD", 32'(CD), 32'(m_cd));
    chk("F", 32'(F), 32'(m_f));
    chk("F_valid", 32'(F_valid), 32'(m_fv));
    chk("busy", 32'(busy), (m_own >= 0) ? 32'd1 : 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1 compare();
  endtask

  initial begin
    int waited;
    rst_n = 1'b0; req = 4'b0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) dat[i] = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 compare();
    rst_n = 1'b1;

    // Full contention: each source gets HM back-to-back transfers, with no gaps
    req = 4'b1111; rdy = 1'b1;
    for (int i = 0; i < 4; i++) dat[i] = W'(i);
    cyc();
    for (int n = 0; n < 16; n++) begin
      cyc();
      chk("seq_fv", 32'(F_valid), 32'd1);
      chk("seq_f", 32'(F), 32'(n / HM));
    end

    // Single source: stream continues across the hold boundary
    req = 4'b0100; dat[2] = 4'h5;
    repeat (3) cyc();
    for (int n = 0; n < 2 * HM + 2; n++) begin
      cyc();
      chk("solo_f", 32'(F), 32'h5);
      chk("solo_fv", 32'(F_valid), 32'd1);
    end

    // Backpressure on source 1 while source 2 is also waiting
    req = 4'b0000; repeat (2) cyc();
    req = 4'b0010; dat[1] = 4'h1; rdy = 1'b1;
    repeat (3) cyc();
    req = 4'b0110; rdy = 1'b0;
    repeat (3) cyc();
    rdy = 1'b1;
    repeat (4) cyc();

    // Early drop on source 3: ptr wraps to 0
    req = 4'b0000; repeat (2) cyc();
    req = 4'b1000; dat[3] = 4'h3; repeat (2) cyc();
    req = 4'b0001; repeat (3) cyc();

    // Fairness: source 0 held, source 2 joins at the start of source 0's grant
    req = 4'b0000; repeat (2) cyc();
    req = 4'b0001; cyc();
    req = 4'b0101; waited = 0;
    while (gnt != 4'b0100 && waited < 3 * HM) begin cyc(); waited++; end
    chk("fair_wait_ok", (waited <= HM + 1) ? 32'd1 : 32'd0, 32'd1);

    // Async reset in the middle of an ownership, with F = A
    req = 4'b0001; dat[0] = 4'hA; rdy = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_f", 32'(F), 32'hA);
    #2 rst_n = 1'b0;
    m_reset();
    #1 compare();
    @(posedge clk);
    #1 compare();
    rst_n = 1'b1;
    req = 4'b1100;
    cyc();
    chk("post_rst_cd", 32'(CD), 32'd2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      rdy = ($urandom_range(3) != 0);
      for (int i = 0; i < 4; i++) dat[i] = W'($urandom);
      if (n == 300) begin
        #2 rst_n = 1'b0;
        m_reset();
        #1 compare();
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
